// File: rtl/sc_sync_pkg.sv
// Shared types and helpers for the frame synchroniser: FSM state encoding,
// metric width derivation and frame-length normalisation.
package sc_sync_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_ALIGN  = 2'd2,
    ST_OUTPUT = 2'd3
  } sync_state_t;

  // Moving-sum metric width: 32-bit power terms summed over cp_size samples.
  function automatic int metric_width(input int cp_size);
    return 32 + $clog2(cp_size + 1);
  endfunction

  // A zero frame length still emits one sample.
  function automatic logic [15:0] eff_frame_len(input logic [15:0] fl);
    return (fl == 16'd0) ? 16'd1 : fl;
  endfunction

endpackage

// File: rtl/sc_delay_ram.sv
// Circular delay line: each write returns the word written DEPTH writes
// earlier (read-before-write on the same slot). Contents clear on reset.
module sc_delay_ram #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;

  // The slot about to be overwritten holds the oldest sample.
  assign rd_data = mem[ptr];

  // Write the new sample into the oldest slot and advance the pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      ptr <= '0;
    end else if (we) begin
      mem[ptr] <= wr_data;
      ptr      <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sc_frame_detector.sv
// Threshold-triggered peak search over a timing metric, followed by
// emission of a frame of delayed signal samples starting at the peak.
module sc_frame_detector
  import sc_sync_pkg::*;
#(
  parameter  int CP_SIZE    = 128,
  parameter  int SEARCH_WIN = 128,
  localparam int MW         = metric_width(CP_SIZE)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic [MW-1:0] metric_tdata,
  input  logic          metric_tlast,
  input  logic          metric_tvalid,
  output logic          metric_tready,
  input  logic [31:0]   s_tdata,
  input  logic          s_tlast,
  input  logic          s_tvalid,
  output logic          s_tready,
  output logic [31:0]   o_tdata,
  output logic          o_tlast,
  output logic          o_tvalid,
  input  logic          o_tready,
  input  logic [MW-1:0] threshold,
  input  logic [15:0]   frame_len,
  output logic          detect_pulse,
  output logic [MW-1:0] peak_metric
);

  localparam int              CW       = (SEARCH_WIN > 1) ? $clog2(SEARCH_WIN) : 1;
  localparam logic [CW-1:0]   LAST_WIN = CW'(SEARCH_WIN - 1);

  sync_state_t   state;
  logic          soft_rst;
  logic          accept_en;
  logic          xfer;
  logic [31:0]   dly_data;
  logic [MW-1:0] max_q;
  logic [CW-1:0] win_cnt;
  logic [CW-1:0] peak_off;
  logic [CW-1:0] drop_cnt;
  logic [15:0]   out_cnt;
  logic [15:0]   flen_q;
  logic [15:0]   flen_eff;
  logic          unused_tlast;

  // Stream tlast carries no meaning for detection.
  assign unused_tlast = metric_tlast ^ s_tlast;

  assign soft_rst = !reset_n || clear;
  assign flen_eff = eff_frame_len(frame_len);

  // Inputs flow freely except when the output register is full and stalled.
  always_comb begin
    accept_en = 1'b1;
    if (state == ST_OUTPUT) begin
      accept_en = !o_tvalid || o_tready;
    end
  end

  assign metric_tready = s_tvalid && accept_en;
  assign s_tready      = metric_tvalid && accept_en;
  assign xfer          = metric_tvalid && s_tvalid && accept_en;

  sc_delay_ram #(
    .DEPTH (SEARCH_WIN),
    .WIDTH (32)
  ) u_delay (
    .clk     (clk),
    .rst     (soft_rst),
    .we      (xfer),
    .wr_data (s_tdata),
    .rd_data (dly_data)
  );

  // Detection FSM: search, track the window maximum, skip to the peak, emit.
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state        <= ST_SEARCH;
      o_tvalid     <= 1'b0;
      o_tlast      <= 1'b0;
      o_tdata      <= '0;
      detect_pulse <= 1'b0;
      peak_metric  <= '0;
      max_q        <= '0;
      win_cnt      <= '0;
      peak_off     <= '0;
      drop_cnt     <= '0;
      out_cnt      <= '0;
      flen_q       <= '0;
    end else begin
      detect_pulse <= 1'b0;
      case (state)
        ST_SEARCH: begin
          if (xfer && (metric_tdata > threshold)) begin
            state    <= ST_TRACK;
            max_q    <= metric_tdata;
            peak_off <= '0;
            win_cnt  <= CW'(1);
          end
        end
        ST_TRACK: begin
          if (xfer) begin
            // Strict compare keeps the earliest of equal peaks.
            if (metric_tdata > max_q) begin
              max_q    <= metric_tdata;
              peak_off <= win_cnt;
            end
            win_cnt <= win_cnt + 1'b1;
            if (win_cnt == LAST_WIN) begin
              state        <= ST_ALIGN;
              drop_cnt     <= '0;
              detect_pulse <= 1'b1;
              peak_metric  <= (metric_tdata > max_q) ? metric_tdata : max_q;
            end
          end
        end
        ST_ALIGN: begin
          // Once enough pre-peak samples are dropped, a transfer in the
          // same cycle already carries the peak sample and is emitted.
          if (drop_cnt == peak_off) begin
            state   <= ST_OUTPUT;
            flen_q  <= flen_eff;
            out_cnt <= '0;
            if (xfer) begin
              o_tdata  <= dly_data;
              o_tvalid <= 1'b1;
              o_tlast  <= (flen_eff == 16'd1);
              out_cnt  <= 16'd1;
            end
          end else if (xfer) begin
            drop_cnt <= drop_cnt + 1'b1;
          end
        end
        ST_OUTPUT: begin
          if (o_tvalid && o_tready && o_tlast) begin
            state    <= ST_SEARCH;
            o_tvalid <= 1'b0;
            o_tlast  <= 1'b0;
            out_cnt  <= '0;
            win_cnt  <= '0;
          end else if (xfer && (out_cnt != flen_q)) begin
            o_tdata  <= dly_data;
            o_tvalid <= 1'b1;
            o_tlast  <= (16'(out_cnt + 16'd1) == flen_q);
            out_cnt  <= out_cnt + 16'd1;
          end else if (o_tready) begin
            o_tvalid <= 1'b0;
          end
        end
        default: state <= ST_SEARCH;
      endcase
    end
  end

endmodule

// File: doc/sc_frame_detector.md
SC_FRAME_DETECTOR -- requirements
Module: sc_frame_detector

Interface
REQ-001 SHALL have parameter CP_SIZE, default 128, moving-sum window length; sets metric width MW = 32+clog2(CP_SIZE+1).
REQ-002 SHALL have parameter SEARCH_WIN, default 128, peak-search window in samples and internal signal delay depth D; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, sole clock.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port clear, input, 1, synchronous active-high soft clear, same effect as reset.
REQ-006 SHALL have ports metric_tdata/tlast/tvalid/tready, in/in/in/out, MW/1/1/1: moving-sum metric N(d), unsigned.
REQ-007 SHALL have ports s_tdata/tlast/tvalid/tready, in/in/in/out, 32/1/1/1: time-aligned signal samples, I/Q 16+16.
REQ-008 SHALL have ports o_tdata/tlast/tvalid/tready, out/out/out/in, 32/1/1/1: synchronised frame output.
REQ-009 SHALL have port threshold, input, MW, detection level, quasi-static.
REQ-010 SHALL have port frame_len, input, 16, output samples per frame, latched on entering OUTPUT.
REQ-011 SHALL have port detect_pulse, output, 1: one-cycle pulse on entering ALIGN.
REQ-012 SHALL have port peak_metric, output, MW: maximum metric of the last detection, held until the next detection.

Function
REQ-013 SHALL transfer one input pair only when metric_tvalid, s_tvalid and accept_en are all high; metric_tready = s_tvalid & accept_en; s_tready = metric_tvalid & accept_en.
REQ-014 SHALL ignore input tlast on both streams.
REQ-015 SHALL set accept_en = 1 in SEARCH, TRACK and ALIGN, and accept_en = (!o_tvalid | o_tready) in OUTPUT.
REQ-016 SHALL write each accepted signal sample into a D-deep circular delay line and, in the same transfer, read the sample accepted D transfers earlier.
REQ-017 SHALL run FSM states SEARCH, TRACK, ALIGN, OUTPUT; reset state SEARCH.
REQ-018 SEARCH: on an accepted metric strictly greater than threshold, SHALL go to TRACK with max := metric, peak_off := 0, win_cnt := 1; equality SHALL NOT trigger.
REQ-019 TRACK: per accepted pair, if metric > max, SHALL set max := metric and peak_off := win_cnt; SHALL increment win_cnt; after D pairs total SHALL go to ALIGN. Ties keep the earliest peak.
REQ-020 ALIGN: SHALL drop peak_off delayed samples, then enter OUTPUT; with peak_off = 0, SHALL enter OUTPUT directly on the next cycle.
REQ-021 OUTPUT: SHALL register each delayed sample into o_tdata with o_tvalid = 1; the first emitted sample SHALL be the sample accepted at the peak index.
REQ-022 OUTPUT: SHALL assert o_tlast on sample number max(frame_len,1); after that sample is accepted, SHALL return to SEARCH. frame_len = 0 SHALL be treated as 1.
REQ-023 SHALL hold o_tdata/o_tlast/o_tvalid stable while o_tvalid & !o_tready.
REQ-024 SHALL NOT evaluate threshold crossings during ALIGN or OUTPUT.
REQ-025 SHALL compare metrics as unsigned MW-bit values, with no saturation or scaling.

Reset
REQ-026 On reset_n = 0 or clear = 1, SHALL clear in the next cycle: state := SEARCH, o_tvalid/o_tlast/detect_pulse := 0, o_tdata := 0, peak_metric := 0, counters := 0, delay-line pointer := 0.
REQ-027 SHALL abort any frame in progress on reset without emitting tlast.
REQ-028 SHALL zero delay-line contents on reset, so samples read before D fills are 0.

Structure
REQ-029 SHALL place the FSM state enum and MW width function in shared package sc_sync_pkg.
REQ-030 SHALL implement the delay line as one sub-module, sc_delay_ram: circular, D-deep, 32-bit, with write enable and read-before-write semantics.

Verification
REQ-031 D=8, frame_len=4, threshold=4, o_tready=1, s_tdata=index, metric=0 except indices 20..27 = 5,9,12,7,3,2,1,0 -> one detect_pulse, peak_metric=12, o_tdata 22,23,24,25, tlast on 25.
REQ-032 Metric 10,10 at indices 20,21, threshold 4 -> frame starts at 20.
REQ-033 Metric equal to threshold everywhere -> no detect_pulse, o_tvalid never high, inputs always accepted.
REQ-034 o_tready low 3 cycles after the 2nd output sample -> o_* held stable, both input treadys low, no sample lost or duplicated.
REQ-035 reset_n low for 1 cycle during OUTPUT -> o_tvalid=0 next cycle, peak_metric=0, new detection found afterwards from SEARCH.
REQ-036 frame_len=0 -> exactly one output sample, with o_tlast=1.
